// File: rtl/tank_motion_ctrl_pkg.sv
// Shared tank definitions: direction/FSM encodings and arena geometry.
package tank_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_MOVE  = 2'd2,
    ST_BLOCK = 2'd3
  } state_e;

  localparam int unsigned TANK_SIZE = 32;
  localparam int unsigned ARENA_W   = 640;
  localparam int unsigned ARENA_H   = 480;

endpackage

// File: rtl/tank_motion_ctrl_move_tick_gen.sv
// Free-running move-tick divider; held at zero while disabled or cleared.
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned CNT_W    = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick = enable & wrap;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || !enable || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-tank motion controller: turns or steps the tank once per move tick.
module tank_motion_ctrl
  import tank_motion_ctrl_pkg::*;
#(
  parameter int unsigned INIT_VER = 400,
  parameter int unsigned INIT_HOR = 32,
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned CNT_W    = 19,
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_VER  = ARENA_H - TANK_SIZE,
  parameter int unsigned MAX_HOR  = ARENA_W - TANK_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       respawn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tank_up_valid,
  input  logic       tank_down_valid,
  input  logic       tank_left_valid,
  input  logic       tank_right_valid,
  output logic [9:0] position_ver,
  output logic [9:0] position_hor,
  output logic [1:0] facing,
  output logic       moving,
  output logic       blocked
);

  logic       tick;
  logic [9:0] ver_q, ver_d, hor_q, hor_d;
  dir_e       facing_q, facing_d, req_dir;
  state_e     state_q, state_d;
  logic       blocked_q, blocked_d;
  logic       req_vld, flag_ok, bound_ok;
  logic [10:0] ver_x, hor_x;

  move_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (respawn),
    .tick   (tick)
  );

  always_comb begin
    req_vld = 1'b1;
    req_dir = DIR_UP;
    if      (btn_up)    req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
    else                req_vld = 1'b0;
  end

  // 11-bit compares so a step at either edge cannot wrap the 10-bit position
  assign ver_x = {1'b0, ver_q};
  assign hor_x = {1'b0, hor_q};

  always_comb begin
    flag_ok  = 1'b0;
    bound_ok = 1'b0;
    case (req_dir)
      DIR_UP:    begin flag_ok = tank_up_valid;    bound_ok = ver_x >= 11'(STEP); end
      DIR_DOWN:  begin flag_ok = tank_down_valid;  bound_ok = ver_x + 11'(STEP) <= 11'(MAX_VER); end
      DIR_LEFT:  begin flag_ok = tank_left_valid;  bound_ok = hor_x >= 11'(STEP); end
      DIR_RIGHT: begin flag_ok = tank_right_valid; bound_ok = hor_x + 11'(STEP) <= 11'(MAX_HOR); end
      default:   ;
    endcase
  end

  always_comb begin
    ver_d     = ver_q;
    hor_d     = hor_q;
    facing_d  = facing_q;
    state_d   = state_q;
    blocked_d = 1'b0;
    if (respawn) begin
      ver_d    = 10'(INIT_VER);
      hor_d    = 10'(INIT_HOR);
      facing_d = DIR_UP;
      state_d  = ST_IDLE;
    end else if (tick) begin
      if (!req_vld) begin
        state_d = ST_IDLE;
      end else if (req_dir != facing_q) begin
        facing_d = req_dir;
        state_d  = ST_TURN;
      end else if (flag_ok && bound_ok) begin
        state_d = ST_MOVE;
        case (req_dir)
          DIR_UP:    ver_d = ver_q - 10'(STEP);
          DIR_DOWN:  ver_d = ver_q + 10'(STEP);
          DIR_LEFT:  hor_d = hor_q - 10'(STEP);
          DIR_RIGHT: hor_d = hor_q + 10'(STEP);
          default:   ;
        endcase
      end else begin
        state_d   = ST_BLOCK;
        blocked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ver_q     <= 10'(INIT_VER);
      hor_q     <= 10'(INIT_HOR);
      facing_q  <= DIR_UP;
      state_q   <= ST_IDLE;
      blocked_q <= 1'b0;
    end else begin
      ver_q     <= ver_d;
      hor_q     <= hor_d;
      facing_q  <= facing_d;
      state_q   <= state_d;
      blocked_q <= blocked_d;
    end
  end

  assign position_ver = ver_q;
  assign position_hor = hor_q;
  assign facing       = facing_q;
  assign moving       = (state_q == ST_MOVE);
  assign blocked      = blocked_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl with a 4-cycle move tick.
module tb_tank_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, respawn;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       up_v, down_v, left_v, right_v;
  logic [9:0] pos_ver, pos_hor;
  logic [1:0] facing;
  logic       moving, blocked;
  int         passed = 0;
  int         total  = 0;

  tank_motion_ctrl #(.TICK_DIV(4), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .respawn          (respawn),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .tank_up_valid    (up_v),
    .tank_down_valid  (down_v),
    .tank_left_valid  (left_v),
    .tank_right_valid (right_v),
    .position_ver     (pos_ver),
    .position_hor     (pos_hor),
    .facing           (facing),
    .moving           (moving),
    .blocked          (blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int h, input int f,
                         input int m, input int b);
    chk({tag, ".ver"}, 16'(pos_ver), 16'(v));
    chk({tag, ".hor"}, 16'(pos_hor), 16'(h));
    chk({tag, ".facing"}, 16'(facing), 16'(f));
    chk({tag, ".moving"}, 16'(moving), 16'(m));
    chk({tag, ".blocked"}, 16'(blocked), 16'(b));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; respawn = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    {up_v, down_v, left_v, right_v} = 4'b1111;
    clocks(2);
    chk_all("rst", 400, 32, 0, 0, 0);
    rst_n = 1'b1;

    // Idle ticks
    clocks(12);
    chk_all("idle", 400, 32, 0, 0, 0);

    // Turn right, then three steps
    btn_right = 1'b1;
    clocks(4);
    chk_all("turn_r", 400, 32, 3, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      clocks(4);
      chk("step_r.hor", 16'(pos_hor), 16'(32 + i));
      chk("step_r.moving", 16'(moving), 16'd1);
    end

    // Blocked by collision flag
    btn_right = 1'b0; btn_up = 1'b1; up_v = 1'b0;
    clocks(4);
    chk_all("turn_u", 400, 35, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      clocks(4);
      chk_all("blk_flag", 400, 35, 0, 0, 1);
      clocks(1);
      chk("blk_flag.pulse_end", 16'(blocked), 16'd0);
      clocks(3);
    end

    // Up+down together: up wins
    up_v = 1'b1; btn_down = 1'b1;
    clocks(4);
    chk_all("updown1", 399, 35, 0, 1, 0);
    clocks(4);
    chk_all("updown2", 398, 35, 0, 1, 0);

    // Drive right to the arena edge
    btn_up = 1'b0; btn_down = 1'b0; btn_right = 1'b1;
    clocks(4);
    chk_all("turn_r2", 398, 35, 3, 0, 0);
    clocks(4 * (608 - 35));
    chk_all("at_edge", 398, 608, 3, 1, 0);
    clocks(4);
    chk_all("blk_bound", 398, 608, 3, 0, 1);
    clocks(1);
    chk("blk_bound.pulse_end", 16'(blocked), 16'd0);
    clocks(3);

    // Disabled: buttons ignored, outputs frozen
    enable = 1'b0; btn_right = 1'b0; btn_left = 1'b1;
    clocks(8);
    chk_all("disabled", 398, 608, 3, 0, 0);
    enable = 1'b1;
    clocks(4);
    chk_all("turn_l", 398, 608, 2, 0, 0);
    clocks(4);
    chk_all("step_l", 398, 607, 2, 1, 0);

    // Respawn coincident with a tick
    clocks(3);
    respawn = 1'b1;
    clocks(1);
    respawn = 1'b0;
    chk_all("respawn", 400, 32, 0, 0, 0);
    clocks(3);
    chk("respawn.cnt_phase", 16'(facing), 16'd0);
    clocks(1);
    chk("respawn.turn_l", 16'(facing), 16'd2);
    clocks(4);
    chk_all("step_l2", 400, 31, 2, 1, 0);

    // Async reset between ticks
    clocks(2);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 400, 32, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
